// File: rtl/fifo_flagged.sv
// Synchronous show-ahead FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module fifo_flagged #(
  parameter int WIDTH              = 8,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_LEVEL  = 2**DEPTH - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Write,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             Read,
  output logic [WIDTH-1:0] ReadData,
  input  logic             Flush,
  input  logic             ClearErrors,
  output logic             Empty,
  output logic             Full,
  output logic             AlmostFull,
  output logic             AlmostEmpty,
  output logic [DEPTH:0]   Count,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int             Entries     = 2**DEPTH;
  localparam logic [DEPTH:0] CountMax    = (DEPTH+1)'(Entries);
  localparam logic [DEPTH:0] CountOne    = (DEPTH+1)'(1);
  localparam logic [DEPTH:0] AfLevel     = (DEPTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [DEPTH:0] AeLevel     = (DEPTH+1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [DEPTH-1:0] PtrOne    = DEPTH'(1);

  logic [WIDTH-1:0] mem [Entries];
  logic [DEPTH-1:0] readPtr;
  logic [DEPTH-1:0] writePtr;

  logic             writeAccept;
  logic             readAccept;
  logic             overflowEvent;
  logic             underflowEvent;
  logic [DEPTH:0]   countNext;
  logic [DEPTH-1:0] readPtrNext;
  logic [DEPTH-1:0] writePtrNext;

  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  assign writeAccept    = Write && (!Full || Read) && !Flush;
  assign readAccept     = Read && !Empty && !Flush;
  assign overflowEvent  = Write && Full && !Read && !Flush;
  assign underflowEvent = Read && Empty && !Flush;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    countNext    = Count;
    readPtrNext  = readPtr;
    writePtrNext = writePtr;
    if (Flush) begin
      countNext    = '0;
      readPtrNext  = '0;
      writePtrNext = '0;
    end else begin
      if (writeAccept) writePtrNext = writePtr + PtrOne;
      if (readAccept)  readPtrNext  = readPtr + PtrOne;
      unique case ({writeAccept, readAccept})
        2'b10:   countNext = Count + CountOne;
        2'b01:   countNext = Count - CountOne;
        default: countNext = Count;
      endcase
    end
  end

  // Flags are registered from next-state occupancy so they never lag Count.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      readPtr     <= '0;
      writePtr    <= '0;
      Count       <= '0;
      Empty       <= 1'b1;
      Full        <= 1'b0;
      AlmostFull  <= 1'b0;
      AlmostEmpty <= 1'b1;
      Overflow    <= 1'b0;
      Underflow   <= 1'b0;
    end else begin
      readPtr     <= readPtrNext;
      writePtr    <= writePtrNext;
      Count       <= countNext;
      Empty       <= (countNext == '0);
      Full        <= (countNext == CountMax);
      AlmostFull  <= (countNext >= AfLevel);
      AlmostEmpty <= (countNext <= AeLevel);
      // A new error event wins over a coincident clear.
      Overflow    <= overflowEvent  || (Overflow  && !ClearErrors);
      Underflow   <= underflowEvent || (Underflow && !ClearErrors);
    end
  end

  // NOTE: the storage array has no reset; the pointers and Count alone define validity.
  always_ff @(posedge Clock) begin
    if (writeAccept) mem[writePtr] <= WriteData;
  end

  assign ReadData = mem[readPtr];

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: directed vector table, async-reset sequence, and randomized
// traffic checked against a queue-based model.
module tb_fifo_flagged;

  localparam int Width = 8;
  localparam int Depth = 2;
  localparam int N     = 2**Depth;
  localparam int Af    = 3;
  localparam int Ae    = 1;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             Write;
  logic [Width-1:0] WriteData;
  logic             Read;
  logic [Width-1:0] ReadData;
  logic             Flush;
  logic             ClearErrors;
  logic             Empty;
  logic             Full;
  logic             AlmostFull;
  logic             AlmostEmpty;
  logic [Depth:0]   Count;
  logic             Overflow;
  logic             Underflow;

  fifo_flagged #(
    .WIDTH(Width), .DEPTH(Depth),
    .ALMOST_FULL_LEVEL(Af), .ALMOST_EMPTY_LEVEL(Ae)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Write(Write), .WriteData(WriteData),
    .Read(Read), .ReadData(ReadData), .Flush(Flush), .ClearErrors(ClearErrors),
    .Empty(Empty), .Full(Full), .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty),
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       c;
    int         cnt;
    logic       ov;
    logic       un;
    logic       chk;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flags are derived from the expected count using the threshold rules directly.
  task automatic checkState(input string tag, input int cnt, input logic ov, input logic un,
                            input logic chk, input logic [7:0] rd);
    check({tag, " Count"}, 32'(Count), 32'(cnt));
    check({tag, " Empty"}, 32'(Empty), 32'(cnt == 0));
    check({tag, " Full"}, 32'(Full), 32'(cnt == N));
    check({tag, " AlmostFull"}, 32'(AlmostFull), 32'(cnt >= Af));
    check({tag, " AlmostEmpty"}, 32'(AlmostEmpty), 32'(cnt <= Ae));
    check({tag, " Overflow"}, 32'(Overflow), 32'(ov));
    check({tag, " Underflow"}, 32'(Underflow), 32'(un));
    if (chk) check({tag, " ReadData"}, 32'(ReadData), 32'(rd));
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r,
                       input logic f, input logic c);
    Write = w; WriteData = d; Read = r; Flush = f; ClearErrors = c;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [7:0] d, input logic r, input logic f,
                              input logic c, input int cnt, input logic ov, input logic un,
                              input logic chk, input logic [7:0] rd);
    vec_t v;
    v.w = w; v.d = d; v.r = r; v.f = f; v.c = c;
    v.cnt = cnt; v.ov = ov; v.un = un; v.chk = chk; v.rd = rd;
    return v;
  endfunction

  task automatic doReset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b0;
    step();
  endtask

  initial begin
    byte unsigned q[$];
    logic         mOv;
    logic         mUn;

    //                w  data  r  f  c  cnt ov un chk rd
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h02, 0, 0, 0, 2, 0, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h03, 0, 0, 0, 3, 0, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0, 4, 0, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h05, 0, 0, 0, 4, 1, 0, 1, 8'h01)); // dropped write
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 3, 1, 0, 1, 8'h02));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 2, 1, 0, 1, 8'h03));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 0, 1, 8'h04));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 1, 1, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h02, 0, 0, 0, 2, 1, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h03, 0, 0, 0, 3, 1, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0, 4, 1, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h05, 1, 0, 0, 4, 1, 0, 1, 8'h02)); // read+write while full
    vecs.push_back(mk(1, 8'h05, 1, 0, 0, 4, 1, 0, 1, 8'h03));
    vecs.push_back(mk(1, 8'h05, 1, 0, 0, 4, 1, 0, 1, 8'h04));
    vecs.push_back(mk(1, 8'h05, 1, 0, 0, 4, 1, 0, 1, 8'h05));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 3, 1, 0, 1, 8'h05));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 2, 1, 0, 1, 8'h05));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 0, 1, 8'h05));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'hAA, 1, 0, 0, 1, 0, 1, 1, 8'hAA)); // read+write while empty
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 8'h00)); // set wins over clear
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0, 1, 1, 8'h11));
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 2, 0, 1, 1, 8'h11));
    vecs.push_back(mk(1, 8'h33, 0, 0, 0, 3, 0, 1, 1, 8'h11));
    vecs.push_back(mk(1, 8'h44, 0, 1, 0, 0, 0, 1, 0, 8'h00)); // flush wins over write
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h00)); // flushed read: no underflow
    vecs.push_back(mk(1, 8'h66, 0, 0, 0, 1, 0, 0, 1, 8'h66)); // pointers restart at 0

    Reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #12;
    checkState("reset-held", 0, 1'b0, 1'b0, 1'b0, 8'h00);
    Reset = 1'b0;
    step();
    checkState("after-reset", 0, 1'b0, 1'b0, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].c);
      step();
      checkState($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].un,
                 vecs[i].chk, vecs[i].rd);
    end

    // Async reset with two entries and a sticky error: outputs clear before any edge.
    doReset();
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 8'h5D, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkState("pre-async", 2, 1'b0, 1'b1, 1'b1, 8'h5C);
    #2 Reset = 1'b1;
    #1 checkState("async-reset", 0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge Clock);
    Reset = 1'b0;
    step();
    checkState("post-async", 0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Randomized traffic against a queue model.
    q.delete();
    mOv = 1'b0;
    mUn = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic       w, r, f, c, wAcc, rAcc;
      logic [7:0] d;
      w = ($urandom_range(99) < 55);
      r = ($urandom_range(99) < 50);
      f = ($urandom_range(99) < 4);
      c = ($urandom_range(99) < 6);
      d = 8'($urandom);
      drive(w, d, r, f, c);

      wAcc = w && (q.size() < N || r) && !f;
      rAcc = r && (q.size() > 0) && !f;
      mOv  = (w && q.size() == N && !r && !f) ? 1'b1 : (c ? 1'b0 : mOv);
      mUn  = (r && q.size() == 0 && !f) ? 1'b1 : (c ? 1'b0 : mUn);
      if (f) q.delete();
      if (rAcc) void'(q.pop_front());
      if (wAcc) q.push_back(d);

      step();
      checkState($sformatf("rand%0d", n), q.size(), mOv, mUn, (q.size() > 0),
                 (q.size() > 0) ? q[0] : 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
- Parametrised synchronous FIFO: show-ahead read, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush.
- Correct simultaneous read/write handling at the full and empty boundaries.
- Sits between the UART receiver/transmitter and the host-side logic as the standard buffering element; supersedes the plain FIFO for new work.

Parameters:
- WIDTH, 8, data bits per entry.
- DEPTH, 4, address bits; capacity N = 2**DEPTH entries.
- ALMOST_FULL_LEVEL, 2**DEPTH-1, AlmostFull asserted when Count >= this value. Legal range 1..N.
- ALMOST_EMPTY_LEVEL, 1, AlmostEmpty asserted when Count <= this value. Legal range 0..N-1.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Write  in  1  push request.
- WriteData  in  WIDTH  data to push.
- Read  in  1  pop request.
- ReadData  out  WIDTH  head-of-queue data, show-ahead.
- Flush  in  1  synchronous empty-the-queue request.
- ClearErrors  in  1  synchronous clear of Overflow/Underflow.
- Empty  out  1  Count == 0.
- Full  out  1  Count == N.
- AlmostFull  out  1  Count >= ALMOST_FULL_LEVEL.
- AlmostEmpty  out  1  Count <= ALMOST_EMPTY_LEVEL.
- Count  out  DEPTH+1  current occupancy, 0..N.
- Overflow  out  1  sticky: a write was dropped.
- Underflow  out  1  sticky: a read hit an empty FIFO.

Behaviour:
- Reset (async, active-high) sets:
  - read/write pointers = 0, Count = 0
  - Empty = 1, Full = 0, AlmostEmpty = 1, AlmostFull = 0
  - Overflow = 0, Underflow = 0
- Storage array is not reset. ReadData is undefined while Empty = 1.
- Reset asserted mid-operation discards all contents immediately; there is no partial state.
- All flags and Count are registered and computed from next-state occupancy, so they are valid in the cycle after the causing edge. They never lag by an extra cycle.
- ReadData = mem[readPtr], combinational from registers. Zero read latency: the first word written appears on ReadData in the cycle after the write edge, when Empty deasserts.
- Write is accepted iff (!Full || Read) && !Flush. An accepted write stores WriteData at writePtr and increments writePtr modulo N.
- Read is accepted iff !Empty && !Flush. An accepted read increments readPtr modulo N.
- Count update:
  - +1 on write only
  - -1 on read only
  - unchanged when both are accepted
- Empty FIFO with Read && Write: the write is accepted, the read is rejected, Count goes 0 -> 1, and Underflow is set.
- Full FIFO with Read && Write: both are accepted and Count stays N. The old head word is the one seen on ReadData that cycle.
- Overflow is set on Write && Full && !Read && !Flush.
- Underflow is set on Read && Empty && !Flush.
- Error flags stay set until ClearErrors or Reset. If ClearErrors coincides with a new error event, the flag ends set (set wins).
- Flush:
  - pointers and Count go to 0 next cycle, and flags follow
  - Write/Read in the same cycle are ignored and raise no errors
  - error flags are not affected by Flush
- Pointers are DEPTH bits and wrap naturally. Full/Empty come from Count, not from pointer comparison.

Test Plan:
- DEPTH=2, AF=3, AE=1. After Reset, write 0x01,0x02,0x03,0x04 on consecutive cycles:
  - Count 1,2,3,4
  - Empty drops after the first edge
  - AlmostEmpty drops at Count=2
  - AlmostFull rises at Count=3, Full rises at Count=4
  - ReadData = 0x01 throughout.
- From full, Write 0x05 without Read -> Overflow = 1, Count stays 4, contents unchanged. Then read 4 times -> ReadData 0x01,0x02,0x03,0x04, Empty = 1 after the 4th pop.
- From full, Read && Write 0x05 for 4 cycles -> Count stays 4, ReadData sequence 0x01..0x04, then head = 0x05 (pointer wrap verified).
- From empty, Read && Write 0xAA -> Count = 1, Underflow = 1, ReadData = 0xAA next cycle. ClearErrors together with Read on the empty FIFO -> Underflow stays 1.
- Count = 3, assert Flush together with Write -> next cycle Count = 0, Empty = 1, no Overflow. Then ClearErrors -> both error flags 0.
- Assert Reset asynchronously between edges with Count = 2 -> outputs return to reset values immediately, without waiting for a clock edge.
